// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, legal key sizes and the
// state encoding used by the decrypt-side request arbiter.
package aes_pkg;

    localparam int AES_BLK = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    function automatic bit key_size_ok(input int k);
        return (k == 128) || (k == 192) || (k == 256);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant+1 upward
// (mod NUM_REQ) and returns the first requester as one-hot and index.
// Ports: req (request vector), last_grant (previous winner),
//        gnt (one-hot or zero), gnt_id (encoded winner, 0 if none).
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id
);

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        idx    = '0;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/aes_dec_arbiter.sv
// Shares one aes_dec core between NUM_REQ requesters: round-robin grant,
// start/done sequencing, and a watchdog that answers with an error when
// the core never completes.
// Ports: clk/rst (sync, active high); req_valid/req_ready/req_ct/req_key
//        per requester; rsp_valid/rsp_ready/rsp_pt/rsp_id/rsp_err response;
//        core_start/core_ct/core_key/core_pt/core_done to the core; busy.
module aes_dec_arbiter
    import aes_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int KEY_SIZE = 256,
    parameter  int TIMEOUT  = 63,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*AES_BLK-1:0]  req_ct,
    input  logic [NUM_REQ*KEY_SIZE-1:0] req_key,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [AES_BLK-1:0]          rsp_pt,
    output logic [ID_W-1:0]             rsp_id,
    output logic                        rsp_err,
    output logic                        core_start,
    output logic [AES_BLK-1:0]          core_ct,
    output logic [KEY_SIZE-1:0]         core_key,
    input  logic [AES_BLK-1:0]          core_pt,
    input  logic                        core_done,
    output logic                        busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    arb_state_t         state;
    arb_state_t         state_nx;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic [ID_W-1:0]    last_grant;
    logic [CNT_W-1:0]   cnt;
    logic               done_q;
    logic               done_rise;
    logic               any_req;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .gnt        (gnt),
        .gnt_id     (gnt_id)
    );

    assign any_req    = |req_valid;
    // A done level still high from an earlier job must not complete this one.
    assign done_rise  = core_done & ~done_q;
    assign req_ready  = (state == ST_IDLE) ? gnt : '0;
    assign core_start = (state == ST_START);
    assign rsp_valid  = (state == ST_RESP);
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (any_req) state_nx = ST_START;
            ST_START: state_nx = ST_WAIT;
            ST_WAIT:  if (done_rise || cnt == CNT_MAX) state_nx = ST_RESP;
            ST_RESP:  if (rsp_ready) state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            core_ct    <= '0;
            core_key   <= '0;
            rsp_pt     <= '0;
            rsp_id     <= '0;
            rsp_err    <= 1'b0;
            cnt        <= '0;
            done_q     <= 1'b0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else begin
            done_q <= core_done;
            unique case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        core_ct  <= req_ct[int'(gnt_id)*AES_BLK +: AES_BLK];
                        core_key <= req_key[int'(gnt_id)*KEY_SIZE +: KEY_SIZE];
                        rsp_id   <= gnt_id;
                    end
                end
                ST_START: cnt <= '0;
                ST_WAIT: begin
                    if (done_rise) begin
                        rsp_pt  <= core_pt;
                        rsp_err <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        rsp_pt  <= '0;
                        rsp_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: if (rsp_ready) last_grant <= rsp_id;
            endcase
        end
    end

endmodule
